// File: rtl/mcpu_pkg.sv
// Shared types and encodings for the multicycle MIPS controller.
// States, instruction classes, pc_src selects and IR field constants.
package mcpu_pkg;

    typedef enum logic [2:0] {
        S_RST = 3'd0,
        S_IF  = 3'd1,
        S_ID  = 3'd2,
        S_EX  = 3'd3,
        S_MEM = 3'd4,
        S_WB  = 3'd5
    } state_t;

    typedef enum logic [3:0] {
        C_RALU  = 4'd0,
        C_IALU  = 4'd1,
        C_LOAD  = 4'd2,
        C_STORE = 4'd3,
        C_BR    = 4'd4,
        C_BRL   = 4'd5,
        C_J     = 4'd6,
        C_JAL   = 4'd7,
        C_JR    = 4'd8,
        C_ILL   = 4'd9
    } iclass_t;

    localparam logic [1:0] PC_PLUS4 = 2'd0;
    localparam logic [1:0] PC_BR    = 2'd1;
    localparam logic [1:0] PC_JMP   = 2'd2;
    localparam logic [1:0] PC_RS    = 2'd3;

    localparam logic [5:0] OP_RTYPE  = 6'b000000;
    localparam logic [5:0] OP_REGIMM = 6'b000001;
    localparam logic [5:0] OP_J      = 6'b000010;
    localparam logic [5:0] OP_JAL    = 6'b000011;
    localparam logic [5:0] OP_BEQ    = 6'b000100;
    localparam logic [5:0] OP_BNE    = 6'b000101;
    localparam logic [5:0] OP_BLEZ   = 6'b000110;
    localparam logic [5:0] OP_BGTZ   = 6'b000111;
    localparam logic [5:0] OP_LB     = 6'b100000;
    localparam logic [5:0] OP_LW     = 6'b100011;
    localparam logic [5:0] OP_SB     = 6'b101000;
    localparam logic [5:0] OP_SW     = 6'b101011;

    localparam logic [5:0] FN_SLL  = 6'b000000;
    localparam logic [5:0] FN_SRL  = 6'b000010;
    localparam logic [5:0] FN_SRA  = 6'b000011;
    localparam logic [5:0] FN_SLLV = 6'b000100;
    localparam logic [5:0] FN_SRLV = 6'b000110;
    localparam logic [5:0] FN_SRAV = 6'b000111;
    localparam logic [5:0] FN_JR   = 6'b001000;
    localparam logic [5:0] FN_ADD  = 6'b100000;
    localparam logic [5:0] FN_ADDU = 6'b100001;
    localparam logic [5:0] FN_SUB  = 6'b100010;
    localparam logic [5:0] FN_SUBU = 6'b100011;
    localparam logic [5:0] FN_AND  = 6'b100100;
    localparam logic [5:0] FN_OR   = 6'b100101;
    localparam logic [5:0] FN_XOR  = 6'b100110;
    localparam logic [5:0] FN_NOR  = 6'b100111;
    localparam logic [5:0] FN_SLT  = 6'b101010;
    localparam logic [5:0] FN_SLTU = 6'b101011;

    localparam logic [4:0] RT_BLTZ   = 5'b00000;
    localparam logic [4:0] RT_BGEZ   = 5'b00001;
    localparam logic [4:0] RT_BLTZAL = 5'b10000;
    localparam logic [4:0] RT_BGEZAL = 5'b10001;

    typedef struct packed {
        logic       imem_req;
        logic       dmem_req;
        logic       dmem_we;
        logic       ir_we;
        logic       pc_we;
        logic [1:0] pc_src;
        logic       reg_we;
        logic       instr_done;
        logic       illegal;
    } ctrl_t;

endpackage

// File: rtl/instr_class_decode.sv
// Combinational IR field to instruction class decode.
// Anything not listed resolves to C_ILL.
module instr_class_decode
    import mcpu_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic [4:0] rt,
    output iclass_t    cls
);

    logic is_ialu;
    logic is_load;
    logic is_store;
    logic is_br;

    assign is_ialu  = (opcode[5:3] == 3'b001);
    assign is_load  = (opcode == OP_LW) || (opcode == OP_LB);
    assign is_store = (opcode == OP_SW) || (opcode == OP_SB);
    assign is_br    = (opcode[5:2] == 4'b0001);

    function automatic iclass_t rtype_class(input logic [5:0] fn);
        iclass_t c;
        c = C_ILL;
        case (fn)
            FN_SLL, FN_SRL, FN_SRA, FN_SLLV, FN_SRLV, FN_SRAV,
            FN_ADD, FN_ADDU, FN_SUB, FN_SUBU,
            FN_AND, FN_OR, FN_XOR, FN_NOR,
            FN_SLT, FN_SLTU: c = C_RALU;
            FN_JR:           c = C_JR;
            default:         c = C_ILL;
        endcase
        return c;
    endfunction

    function automatic iclass_t regimm_class(input logic [4:0] sub);
        iclass_t c;
        c = C_ILL;
        case (sub)
            RT_BLTZ, RT_BGEZ:     c = C_BR;
            RT_BLTZAL, RT_BGEZAL: c = C_BRL;
            default:              c = C_ILL;
        endcase
        return c;
    endfunction

    always_comb begin
        cls = C_ILL;
        unique case (1'b1)
            (opcode == OP_RTYPE):  cls = rtype_class(funct);
            (opcode == OP_REGIMM): cls = regimm_class(rt);
            (opcode == OP_J):      cls = C_J;
            (opcode == OP_JAL):    cls = C_JAL;
            is_br:                 cls = C_BR;
            is_ialu:               cls = C_IALU;
            is_load:               cls = C_LOAD;
            is_store:              cls = C_STORE;
            default:               cls = C_ILL;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle IF/ID/EX/MEM/WB sequencer issuing datapath strobes.
// Memory completion is a fixed wait count or a mem_rdy handshake.
module multicycle_ctrl
    import mcpu_pkg::*;
#(
    parameter int MEM_LAT = 1,
    parameter int USE_RDY = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic [4:0] rt,
    input  logic       br_taken,
    input  logic       mem_rdy,
    output logic       imem_req,
    output logic       dmem_req,
    output logic       dmem_we,
    output logic       ir_we,
    output logic       pc_we,
    output logic [1:0] pc_src,
    output logic       reg_we,
    output logic [2:0] state,
    output logic       instr_done,
    output logic       illegal
);

    localparam int CW = $clog2(MEM_LAT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(MEM_LAT - 1);

    state_t        state_q;
    state_t        state_d;
    iclass_t       cls_q;
    iclass_t       cls_dec;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          waiting;
    logic          mem_done;
    ctrl_t         ctl;

    instr_class_decode u_dec (
        .opcode (opcode),
        .funct  (funct),
        .rt     (rt),
        .cls    (cls_dec)
    );

    assign waiting  = (state_q == S_IF) || (state_q == S_MEM);
    assign mem_done = waiting &&
                      ((USE_RDY != 0) ? mem_rdy : (cnt_q == CNT_LAST));

    // Counter runs only while a request is outstanding; zero elsewhere.
    always_comb begin
        cnt_d = '0;
        if (waiting && !mem_done) begin
            if (cnt_q != CNT_LAST) begin
                cnt_d = cnt_q + 1'b1;
            end else begin
                cnt_d = cnt_q;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_RST;
            cnt_q   <= '0;
            cls_q   <= C_ILL;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (state_q == S_ID) begin
                cls_q <= cls_dec;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        ctl     = '0;
        case (state_q)
            S_RST: state_d = S_IF;
            S_IF: begin
                ctl.imem_req = 1'b1;
                if (mem_done) begin
                    ctl.ir_we  = 1'b1;
                    ctl.pc_we  = 1'b1;
                    ctl.pc_src = PC_PLUS4;
                    state_d    = S_ID;
                end
            end
            // ID acts on the live decode; the latched copy drives later states.
            S_ID: begin
                if (cls_dec == C_ILL) begin
                    ctl.illegal    = 1'b1;
                    ctl.instr_done = 1'b1;
                    state_d        = S_IF;
                end else begin
                    state_d = S_EX;
                end
            end
            S_EX: begin
                case (cls_q)
                    C_BR: begin
                        ctl.pc_we      = br_taken;
                        ctl.pc_src     = PC_BR;
                        ctl.instr_done = 1'b1;
                        state_d        = S_IF;
                    end
                    C_BRL: begin
                        ctl.pc_we  = br_taken;
                        ctl.pc_src = PC_BR;
                        state_d    = S_WB;
                    end
                    C_J: begin
                        ctl.pc_we      = 1'b1;
                        ctl.pc_src     = PC_JMP;
                        ctl.instr_done = 1'b1;
                        state_d        = S_IF;
                    end
                    C_JAL: begin
                        ctl.pc_we  = 1'b1;
                        ctl.pc_src = PC_JMP;
                        state_d    = S_WB;
                    end
                    C_JR: begin
                        ctl.pc_we      = 1'b1;
                        ctl.pc_src     = PC_RS;
                        ctl.instr_done = 1'b1;
                        state_d        = S_IF;
                    end
                    C_LOAD, C_STORE: state_d = S_MEM;
                    C_RALU, C_IALU:  state_d = S_WB;
                    default:         state_d = S_IF;
                endcase
            end
            S_MEM: begin
                ctl.dmem_req = 1'b1;
                ctl.dmem_we  = (cls_q == C_STORE);
                if (mem_done) begin
                    if (cls_q == C_STORE) begin
                        ctl.instr_done = 1'b1;
                        state_d        = S_IF;
                    end else begin
                        state_d = S_WB;
                    end
                end
            end
            S_WB: begin
                ctl.reg_we     = 1'b1;
                ctl.instr_done = 1'b1;
                state_d        = S_IF;
            end
            default: state_d = S_RST;
        endcase
    end

    assign imem_req   = ctl.imem_req;
    assign dmem_req   = ctl.dmem_req;
    assign dmem_we    = ctl.dmem_we;
    assign ir_we      = ctl.ir_we;
    assign pc_we      = ctl.pc_we;
    assign pc_src     = ctl.pc_src;
    assign reg_we     = ctl.reg_we;
    assign instr_done = ctl.instr_done;
    assign illegal    = ctl.illegal;
    assign state      = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed cycle-by-cycle bench for multicycle_ctrl in three configurations.
// Per-cycle stimulus and expected strobes flow through a scoreboard queue.
`timescale 1ns/1ps
module tb_multicycle_ctrl;
    import mcpu_pkg::*;

    typedef struct packed {
        logic [2:0] st;
        logic       im;
        logic       dm;
        logic       dwe;
        logic       ir;
        logic       pw;
        logic [1:0] ps;
        logic       rw;
        logic       dn;
        logic       il;
    } obs_t;

    typedef struct packed {
        logic       rst;
        logic       br;
        logic       rdy;
        logic [5:0] op;
        logic [5:0] fn;
        logic [4:0] rt;
        obs_t       exp;
    } item_t;

    localparam logic L = 1'b0;
    localparam logic H = 1'b1;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [5:0] opcode = '0;
    logic [5:0] funct = '0;
    logic [4:0] rt = '0;
    logic       br_taken = 1'b0;
    logic       mem_rdy = 1'b0;
    wire [12:0] w1;
    wire [12:0] w3;
    wire [12:0] wr;

    int n_assert = 0;
    int n_fail = 0;
    int sel = 0;
    logic [5:0] cur_op = '0;
    logic [5:0] cur_fn = '0;
    logic [4:0] cur_rt = '0;
    item_t stim_q[$];
    obs_t  exp_q[$];

    always #5 clk = ~clk;

    multicycle_ctrl #(.MEM_LAT(1), .USE_RDY(0)) u_lat1 (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .rt(rt),
        .br_taken(br_taken), .mem_rdy(mem_rdy),
        .imem_req(w1[9]), .dmem_req(w1[8]), .dmem_we(w1[7]),
        .ir_we(w1[6]), .pc_we(w1[5]), .pc_src(w1[4:3]), .reg_we(w1[2]),
        .state(w1[12:10]), .instr_done(w1[1]), .illegal(w1[0])
    );

    multicycle_ctrl #(.MEM_LAT(3), .USE_RDY(0)) u_lat3 (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .rt(rt),
        .br_taken(br_taken), .mem_rdy(mem_rdy),
        .imem_req(w3[9]), .dmem_req(w3[8]), .dmem_we(w3[7]),
        .ir_we(w3[6]), .pc_we(w3[5]), .pc_src(w3[4:3]), .reg_we(w3[2]),
        .state(w3[12:10]), .instr_done(w3[1]), .illegal(w3[0])
    );

    multicycle_ctrl #(.MEM_LAT(1), .USE_RDY(1)) u_rdy (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .rt(rt),
        .br_taken(br_taken), .mem_rdy(mem_rdy),
        .imem_req(wr[9]), .dmem_req(wr[8]), .dmem_we(wr[7]),
        .ir_we(wr[6]), .pc_we(wr[5]), .pc_src(wr[4:3]), .reg_we(wr[2]),
        .state(wr[12:10]), .instr_done(wr[1]), .illegal(wr[0])
    );

    function automatic obs_t ex(input logic [2:0] st,
                                input logic im, input logic dm,
                                input logic dwe, input logic ir,
                                input logic pw, input logic [1:0] ps,
                                input logic rw, input logic dn,
                                input logic il);
        obs_t o;
        o = {st, im, dm, dwe, ir, pw, ps, rw, dn, il};
        return o;
    endfunction

    function automatic obs_t o_if(input logic ld);
        return ex(S_IF, H, L, L, ld, ld, PC_PLUS4, L, L, L);
    endfunction

    function automatic obs_t o_id(input logic il);
        return ex(S_ID, L, L, L, L, L, PC_PLUS4, L, il, il);
    endfunction

    function automatic obs_t o_ex(input logic pw, input logic [1:0] ps,
                                  input logic dn);
        return ex(S_EX, L, L, L, L, pw, ps, L, dn, L);
    endfunction

    function automatic obs_t o_mem(input logic we, input logic dn);
        return ex(S_MEM, L, H, we, L, L, PC_PLUS4, L, dn, L);
    endfunction

    function automatic obs_t o_wb();
        return ex(S_WB, L, L, L, L, L, PC_PLUS4, H, H, L);
    endfunction

    task automatic ins(input logic [5:0] op, input logic [5:0] fn,
                       input logic [4:0] r);
        cur_op = op;
        cur_fn = fn;
        cur_rt = r;
    endtask

    task automatic add(input logic r, input logic br, input logic rdy,
                       input obs_t e);
        item_t it;
        it = {r, br, rdy, cur_op, cur_fn, cur_rt, e};
        stim_q.push_back(it);
    endtask

    task automatic step(input logic br, input logic rdy, input obs_t e);
        add(H, br, rdy, e);
    endtask

    task automatic add_reset();
        add(L, L, L, '0);
        add(L, L, L, '0);
        add(H, L, L, '0);
    endtask

    task automatic run(input string name);
        item_t it;
        obs_t  got;
        obs_t  want;
        int    cyc;
        cyc = 0;
        while (stim_q.size() > 0) begin
            @(posedge clk);
            #1;
            it = stim_q.pop_front();
            rst_n    = it.rst;
            br_taken = it.br;
            mem_rdy  = it.rdy;
            opcode   = it.op;
            funct    = it.fn;
            rt       = it.rt;
            exp_q.push_back(it.exp);
            @(negedge clk);
            got  = (sel == 0) ? obs_t'(w1) : (sel == 1) ? obs_t'(w3) : obs_t'(wr);
            want = exp_q.pop_front();
            n_assert++;
            assert (got === want) else begin
                n_fail++;
                $error("FAIL %s cyc %0d: observed %h expected %h",
                       name, cyc, got, want);
            end
            cyc++;
        end
    endtask

    initial begin
        sel = 0;
        ins(OP_RTYPE, FN_ADDU, 5'd0);
        add_reset();
        step(L, L, o_if(H));
        step(L, L, o_id(L));
        step(L, L, o_ex(L, PC_PLUS4, L));
        step(L, L, o_wb());
        step(L, L, o_if(H));
        run("addu_lat1");

        sel = 1;
        ins(OP_LW, 6'd0, 5'd0);
        add_reset();
        step(L, L, o_if(L));
        step(L, L, o_if(L));
        step(L, L, o_if(H));
        step(L, L, o_id(L));
        step(L, L, o_ex(L, PC_PLUS4, L));
        step(L, L, o_mem(L, L));
        step(L, L, o_mem(L, L));
        step(L, L, o_mem(L, L));
        step(L, L, o_wb());
        step(L, L, o_if(L));
        run("lw_lat3");

        sel = 2;
        ins(OP_SW, 6'd0, 5'd0);
        add_reset();
        step(L, L, o_if(L));
        step(L, H, o_if(H));
        step(L, H, o_id(L));
        step(L, H, o_ex(L, PC_PLUS4, L));
        for (int i = 0; i < 4; i++) begin
            step(L, L, o_mem(H, L));
        end
        step(L, H, o_mem(H, H));
        step(L, L, o_if(L));
        run("sw_rdy");

        sel = 0;
        ins(OP_BEQ, 6'd0, 5'd0);
        add_reset();
        step(H, L, o_if(H));
        step(H, L, o_id(L));
        step(L, L, o_ex(L, PC_BR, H));
        step(L, L, o_if(H));
        step(L, L, o_id(L));
        step(H, L, o_ex(H, PC_BR, H));
        step(L, L, o_if(H));
        run("beq");

        ins(OP_REGIMM, 6'd0, RT_BGEZAL);
        add_reset();
        step(L, L, o_if(H));
        step(L, L, o_id(L));
        step(L, L, o_ex(L, PC_BR, L));
        step(L, L, o_wb());
        ins(OP_RTYPE, FN_JR, 5'd0);
        step(L, L, o_if(H));
        step(L, L, o_id(L));
        step(L, L, o_ex(H, PC_RS, H));
        ins(OP_J, 6'd0, 5'd0);
        step(L, L, o_if(H));
        step(L, L, o_id(L));
        step(L, L, o_ex(H, PC_JMP, H));
        ins(OP_JAL, 6'd0, 5'd0);
        step(L, L, o_if(H));
        step(L, L, o_id(L));
        step(L, L, o_ex(H, PC_JMP, L));
        step(L, L, o_wb());
        step(L, L, o_if(H));
        run("link_jump");

        ins(6'b111111, 6'd0, 5'd0);
        add_reset();
        step(L, L, o_if(H));
        step(L, L, o_id(H));
        step(L, L, o_if(H));
        run("illegal");

        sel = 1;
        ins(OP_SW, 6'd0, 5'd0);
        add_reset();
        step(L, L, o_if(L));
        step(L, L, o_if(L));
        step(L, L, o_if(H));
        step(L, L, o_id(L));
        step(L, L, o_ex(L, PC_PLUS4, L));
        step(L, L, o_mem(H, L));
        add(L, L, L, '0);
        add(L, L, L, '0);
        add(H, L, L, '0);
        step(L, L, o_if(L));
        run("rst_in_mem");

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
